// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and sequencing controller for the five-stage pipeline. Produces
//   the load enables, flushes and bubbles for the PC and the four pipeline
//   registers, resolving load-use stalls, taken branches (resolved in MEM)
//   and multi-cycle data-memory waits. A watchdog flags memory waits that
//   are too long, and saturating counters record stall and flush cycles.
//
// Parameters
//   CNT_W    width of stall_count / flush_count
//   TIMEOUT  consecutive frozen cycles before mem_timeout sets (>= 1)
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   id_instr          instruction held in IF/ID
//   ex_memread/ex_rd  load flag and destination register of ID/EX
//   mem_branch_taken  EX/MEM branch resolved taken
//   mem_req           EX/MEM instruction accesses data memory
//   dmem_ready        data memory completes this cycle
//   pc_write .. memwb_bubble  combinational pipeline controls
//   mem_timeout       sticky memory-wait error (registered)
//   stall_count       load-use stall cycles, saturating (registered)
//   flush_count       branch flush cycles, saturating (registered)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_instr,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  logic [0:0]        state_q, state_d;
  logic              lu_stalled_q, lu_stalled_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       uses_rs1, uses_rs2;
  logic       lu_hazard, freeze, stall_fire, flush_fire;

  // Funct and immediate fields play no part in hazard detection.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:7]};

  assign opcode = id_instr[6:0];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_LOAD, OP_OPIMM:         uses_rs1 = 1'b1;
      OP_STORE, OP_BRANCH, OP_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign lu_hazard = ex_memread && (ex_rd != 5'd0) &&
                     ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
  assign freeze    = mem_req && !dmem_ready;

  // A frozen cycle defers both branch and load-use handling: the pipeline is
  // held, so the same condition is re-evaluated in the release cycle.
  assign flush_fire = !reset && !freeze && mem_branch_taken;
  assign stall_fire = !reset && !freeze && !mem_branch_taken &&
                      lu_hazard && !lu_stalled_q;

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (flush_fire) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else if (stall_fire) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    lu_stalled_d  = freeze ? lu_stalled_q : stall_fire;
    wait_cnt_d    = '0;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;

    case (state_q)
      RUN:      if (freeze)  state_d = MEM_WAIT;
      MEM_WAIT: if (!freeze) state_d = RUN;
      default:  state_d = RUN;
    endcase

    // The first frozen cycle is still in RUN and counts as one.
    if (freeze) begin
      if (state_q == RUN)          wait_cnt_d = WAIT_W'(1);
      else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      else                         wait_cnt_d = wait_cnt_q;
    end

    mem_timeout_d = mem_timeout_q || (wait_cnt_d == WAIT_MAX);

    if (stall_fire && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
    if (flush_fire && (flush_count_q != '1)) flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // values from before this edge, independent of statement order.
    if (reset) begin
      state_q       <= RUN;
      lu_stalled_q  <= 1'b0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      lu_stalled_q  <= lu_stalled_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl. Two instances share the stimulus: one
//   with default widths, one with CNT_W=2 to exercise counter saturation.
//   Control outputs are packed as
//   {pc_write, ifid_write, ifid_flush, idex_write,
//    idex_bubble, exmem_write, exmem_flush, memwb_bubble}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam logic [7:0] C_NORMAL = 8'b1101_0100;
  localparam logic [7:0] C_STALL  = 8'b0001_1100;
  localparam logic [7:0] C_FLUSH  = 8'b1111_1110;
  localparam logic [7:0] C_FREEZE = 8'b0000_0001;
  localparam logic [7:0] C_RESET  = 8'b0000_0000;

  localparam logic [31:0] I_ADD_X6_X5_X7 = 32'h0072_8333;
  localparam logic [31:0] I_ADDI_X1_X2_5 = 32'h0051_0093;
  localparam logic [31:0] I_ADDI_X1_X0_0 = 32'h0000_0093;
  localparam logic [31:0] I_SD_X5_0_X2   = 32'h0051_3023;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id_instr;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        mem_branch_taken;
  logic        mem_req;
  logic        dmem_ready;

  logic        pc_write, ifid_write, ifid_flush, idex_write;
  logic        idex_bubble, exmem_write, exmem_flush, memwb_bubble;
  logic        mem_timeout;
  logic [31:0] stall_count, flush_count;

  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_write;
  logic        s_idex_bubble, s_exmem_write, s_exmem_flush, s_memwb_bubble;
  logic        s_mem_timeout;
  logic [1:0]  s_stall_count, s_flush_count;

  logic [7:0]  ctrl;
  assign ctrl = {pc_write, ifid_write, ifid_flush, idex_write,
                 idex_bubble, exmem_write, exmem_flush, memwb_bubble};

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .id_instr(id_instr), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_write(idex_write), .idex_bubble(idex_bubble),
    .exmem_write(exmem_write), .exmem_flush(exmem_flush),
    .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_ctrl #(.CNT_W(2), .TIMEOUT(16)) dut_sat (
    .clk(clk), .reset(reset), .id_instr(id_instr), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .ifid_flush(s_ifid_flush), .idex_write(s_idex_write),
    .idex_bubble(s_idex_bubble), .exmem_write(s_exmem_write),
    .exmem_flush(s_exmem_flush), .memwb_bubble(s_memwb_bubble),
    .mem_timeout(s_mem_timeout), .stall_count(s_stall_count),
    .flush_count(s_flush_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_instr         = 32'h0000_0013;
    ex_memread       = 1'b0;
    ex_rd            = 5'd0;
    mem_branch_taken = 1'b0;
    mem_req          = 1'b0;
    dmem_ready       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Reset state
    #1 check("reset_ctrl", ctrl, C_RESET);
    tick();
    check("reset_stall_cnt", stall_count, 0);
    check("reset_flush_cnt", flush_count, 0);
    check("reset_timeout", mem_timeout, 0);
    reset = 1'b0;
    #1 check("idle_ctrl", ctrl, C_NORMAL);

    // Load-use stall on rs1, single stall cycle
    id_instr = I_ADD_X6_X5_X7; ex_memread = 1'b1; ex_rd = 5'd5;
    #1 check("lu_cycle0", ctrl, C_STALL);
    tick();
    check("lu_cycle1", ctrl, C_NORMAL);
    check("lu_stall_cnt", stall_count, 1);
    ex_memread = 1'b0;
    tick();

    // No false hazard: addi has rs2 field = 5 but does not use rs2
    id_instr = I_ADDI_X1_X2_5; ex_memread = 1'b1; ex_rd = 5'd5;
    #1 check("no_hz_addi_rs2", ctrl, C_NORMAL);
    // Load to x0 never hazards even when rs1 = x0
    id_instr = I_ADDI_X1_X0_0; ex_rd = 5'd0;
    #1 check("no_hz_x0", ctrl, C_NORMAL);
    // Store uses rs2: sd x5 matches load to x5
    id_instr = I_SD_X5_0_X2; ex_rd = 5'd5;
    #1 check("lu_store_rs2", ctrl, C_STALL);
    tick();
    check("lu_store_cnt", stall_count, 2);
    ex_memread = 1'b0;
    tick();

    // Branch beats load-use
    do_reset();
    id_instr = I_ADD_X6_X5_X7; ex_memread = 1'b1; ex_rd = 5'd5; mem_branch_taken = 1'b1;
    #1 check("br_ctrl", ctrl, C_FLUSH);
    tick();
    check("br_flush_cnt", flush_count, 1);
    check("br_stall_cnt", stall_count, 0);
    mem_branch_taken = 1'b0;
    #1 check("br_then_lu", ctrl, C_STALL);
    tick();
    check("br_then_lu_cnt", stall_count, 1);
    idle_inputs();
    tick();

    // Memory wait of 3 cycles with a branch pending: freeze wins
    mem_req = 1'b1; dmem_ready = 1'b0; mem_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("mw_freeze", ctrl, C_FREEZE);
      tick();
    end
    check("mw_flush_held", flush_count, 1);
    dmem_ready = 1'b1;
    #1 check("mw_release_br", ctrl, C_FLUSH);
    tick();
    check("mw_flush_cnt", flush_count, 2);
    check("mw_timeout", mem_timeout, 0);
    idle_inputs();
    #1 check("mw_after", ctrl, C_NORMAL);
    tick();

    // Timeout after 16 consecutive frozen cycles
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("to_cycle15", mem_timeout, 0);
    tick();
    check("to_cycle16", mem_timeout, 1);
    dmem_ready = 1'b1;
    #1 check("to_release_ctrl", ctrl, C_NORMAL);
    tick();
    check("to_sticky", mem_timeout, 1);
    idle_inputs();
    do_reset();
    check("to_cleared", mem_timeout, 0);

    // Reset mid-MEM_WAIT returns to normal operation
    mem_req = 1'b1;
    tick();
    reset = 1'b1;
    #1 check("rst_mw_ctrl", ctrl, C_RESET);
    tick();
    reset = 1'b0; mem_req = 1'b0;
    #1 check("rst_mw_after", ctrl, C_NORMAL);

    // Saturation: 5 stall events, CNT_W=2 saturates at 3
    for (int i = 0; i < 5; i++) begin
      id_instr = I_ADD_X6_X5_X7; ex_memread = 1'b1; ex_rd = 5'd5;
      tick();
      ex_memread = 1'b0;
      tick();
      if (i == 2) check("sat_at3", s_stall_count, 3);
    end
    check("sat_wide", stall_count, 5);
    check("sat_narrow", s_stall_count, 3);

    // Reset mid-stall
    id_instr = I_ADD_X6_X5_X7; ex_memread = 1'b1; ex_rd = 5'd5;
    #1 check("rs_stall", ctrl, C_STALL);
    reset = 1'b1;
    #1 check("rs_pcw_reset", pc_write, 0);
    tick();
    check("rs_cnt_wide", stall_count, 0);
    check("rs_cnt_narrow", s_stall_count, 0);
    reset = 1'b0;
    #1 check("rs_restall", ctrl, C_STALL);
    tick();
    check("rs_after_ctrl", ctrl, C_NORMAL);
    check("rs_after_cnt", stall_count, 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage RISC-V core. Sits beside the decode stage (where the immediate generator and register file read the IF/ID instruction) and issues the write-enable, flush and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three conditions:

- Load-use stalls.
- Taken-branch flushes, with branches resolved in MEM.
- Multi-cycle data-memory waits, with a timeout watchdog and saturating event counters.

## Interface
- CNT_W, 32: width of the stall and flush event counters.
- TIMEOUT, 16: consecutive frozen cycles before mem_timeout asserts (at least 1).

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_instr  in  32  instruction in IF/ID
- ex_memread  in  1  instruction in ID/EX is a load
- ex_rd  in  5  destination register of ID/EX instruction
- mem_branch_taken  in  1  branch in EX/MEM resolved taken
- mem_req  in  1  EX/MEM instruction accesses data memory (ld/sd)
- dmem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads NOP
- idex_write  out  1  ID/EX load enable
- idex_bubble  out  1  ID/EX loads zeroed control signals
- exmem_write  out  1  EX/MEM load enable
- exmem_flush  out  1  EX/MEM loads zeroed control signals
- memwb_bubble  out  1  MEM/WB loads zeroed control signals
- mem_timeout  out  1  sticky memory-wait error
- stall_count  out  CNT_W  load-use stall cycles, saturating
- flush_count  out  CNT_W  branch flush cycles, saturating

## Operation
- Decode from id_instr:
  - opcode = [6:0], rs1 = [19:15], rs2 = [24:20].
  - uses_rs1 holds for opcodes 0000011, 0100011, 1100011, 0110011 and 0010011.
  - uses_rs2 holds for opcodes 0100011, 1100011 and 0110011 only.
- lu_hazard = ex_memread AND ex_rd≠0 AND ((uses_rs1 AND rs1==ex_rd) OR (uses_rs2 AND rs2==ex_rd)).
- freeze = mem_req AND NOT dmem_ready.
- Per-cycle priority, highest first:
  1. reset: pc_write, ifid_write, idex_write and exmem_write are 0. All flush/bubble outputs are 0.
  2. freeze:
     - All *_write are 0. ifid_flush, idex_bubble and exmem_flush are 0. memwb_bubble is 1.
     - mem_branch_taken and lu_hazard are ignored this cycle.
  3. mem_branch_taken:
     - All *_write are 1. ifid_flush, idex_bubble and exmem_flush are 1. memwb_bubble is 0.
     - lu_hazard is ignored. flush_count increments.
  4. lu_hazard AND NOT lu_stalled:
     - pc_write and ifid_write are 0. idex_write and exmem_write are 1.
     - idex_bubble is 1. All other flush/bubble outputs are 0.
     - stall_count increments.
  5. Otherwise: all *_write are 1 and all flush/bubble outputs are 0.
- lu_stalled register:
  - Set when rule 4 fires.
  - Cleared in any non-frozen cycle where rule 4 does not fire.
  - Held during freeze.
  - Guarantees at most one stall cycle per load.
- FSM, states RUN and MEM_WAIT:
  - RUN → MEM_WAIT when freeze.
  - MEM_WAIT stays while freeze.
  - MEM_WAIT → RUN on the first cycle with dmem_ready=1 or mem_req=0. That cycle is not frozen, and rules 3–5 apply.
- Watchdog wait_cnt:
  - Counts consecutive frozen cycles, including the first cycle (in RUN).
  - Saturates at TIMEOUT.
  - Clears in any non-frozen cycle.
- mem_timeout sets at the edge where wait_cnt reaches TIMEOUT. It stays set until reset.
- Counters saturate at all-ones. Freeze cycles are counted in neither counter.

## Timing
- All write, flush and bubble outputs are combinational from the current inputs, lu_stalled and reset. There is zero-cycle latency: they take effect at the next rising edge.
- mem_timeout, stall_count and flush_count are registered and update at the rising edge after the causing cycle.
- Reset is sampled at the rising edge. The state after reset is:
  - state = RUN.
  - lu_stalled = 0 and wait_cnt = 0.
  - mem_timeout = 0, stall_count = 0, flush_count = 0.
- Reset asserted mid-MEM_WAIT or mid-stall aborts the operation. The block returns to RUN on the next edge.
- Simultaneous freeze and branch: freeze wins. The branch takes effect in the release cycle because EX/MEM was held.

## Test plan
- **Load-use stall.**
  - Stimulus: ex_memread=1, ex_rd=5, id_instr=0x00728333 (add x6,x5,x7), all inputs held for two cycles.
  - Cycle 0 requires pc_write=0, ifid_write=0, idex_bubble=1.
  - Cycle 1 requires all writes 1 and no bubble.
  - stall_count=1.
- **No false hazard.**
  - Stimulus: id_instr=0x00510093 (addi x1,x2,5; rs2 field=5), ex_memread=1, ex_rd=5 → no stall.
  - Same stimulus with ex_rd=0 and rs1=0 → no stall.
- **Branch beats load-use.**
  - Stimulus: load-use case above plus mem_branch_taken=1.
  - Requires ifid_flush=idex_bubble=exmem_flush=1 and pc_write=1.
  - flush_count=1, stall_count=0.
- **Memory wait.**
  - Stimulus: mem_req=1, dmem_ready=0 for 3 cycles, then dmem_ready=1.
  - Requires 3 cycles of all writes 0 with memwb_bubble=1, then normal operation.
  - State returns to RUN. mem_timeout=0.
- **Timeout.**
  - Stimulus: freeze for 16 cycles.
  - Requires mem_timeout=1 from the edge ending cycle 16. It stays 1 after dmem_ready rises.
  - Asserting reset for one cycle clears it to 0.
- **Saturation and reset.**
  - With CNT_W=2, 5 stall events → stall_count=3.
  - Reset mid-stall → counters 0, pc_write=0 during reset, normal operation after.
